// File: rtl/br_resolve_queue_pkg.sv
// Shared types and constants for the branch-resolve / BHT training queue.
// The record is what the BHT needs to retrain one entry after a mispredict.
package br_resolve_queue_pkg;

    localparam logic [31:0] PC_FALLTHRU = 32'd8;
    localparam int          RECORD_W    = 65;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } br_rec_t;

    // Not-taken branches fall through past the delay slot.
    function automatic logic [31:0] nextFetchPc(input logic        taken,
                                                input logic [31:0] pc,
                                                input logic [31:0] target);
        return taken ? target : pc + PC_FALLTHRU;
    endfunction

endpackage

// File: rtl/br_resolve_queue_sync_fifo.sv
// Synchronous FIFO with combinational head, occupancy count and async active-low reset.
// A pop on the same cycle as a push frees the slot, so a full FIFO still accepts the push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             pushOk, popOk;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];

    assign popOk  = pop_i & ~empty_o;
    assign pushOk = push_i & (~full_o | popOk);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (popOk) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        if (pushOk && !popOk) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!pushOk && popOk) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Entry storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/br_resolve_queue.sv
// Resolves EX-stage branches against the fetch-time prediction, raises a registered flush
// on a mispredict, and queues training records that drain one per cycle into the BHT.
module br_resolve_queue
    import br_resolve_queue_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_is_br,
    input  logic             ex_taken,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic [31:0]      ex_pred_target,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             br_update,
    output logic [31:0]      br_pc,
    output logic [31:0]      br_target,
    output logic             br_is,
    output logic [CNT_W-1:0] cnt_br,
    output logic [CNT_W-1:0] cnt_mis,
    output logic [CNT_W-1:0] cnt_drop,
    output logic             q_full
);

    localparam int QAW = $clog2(QDEPTH);

    logic              fire, mis, pop, drop;
    logic [31:0]       actualNext;
    br_rec_t           rec, head;
    logic [RECORD_W-1:0] headBits;
    logic              fifoFull, fifoEmpty;
    logic [QAW:0]      fifoCount;

    logic              flush_q, flush_d;
    logic [31:0]       redirect_q, redirect_d;
    logic              upd_q, upd_d;
    logic [31:0]       brPc_q, brPc_d;
    logic [31:0]       brTarget_q, brTarget_d;
    logic              brIs_q, brIs_d;
    logic [CNT_W-1:0]  cntBr_q, cntBr_d;
    logic [CNT_W-1:0]  cntMis_q, cntMis_d;
    logic [CNT_W-1:0]  cntDrop_q, cntDrop_d;

    // A stalled EX result is not consumed, so it neither trains nor counts until it fires.
    assign fire       = ex_valid & ~ex_stall & ex_is_br;
    assign actualNext = nextFetchPc(ex_taken, ex_pc, ex_target);
    assign mis        = fire & (actualNext != ex_pred_target);

    always_comb begin
        rec        = '0;
        rec.pc     = ex_pc;
        rec.target = actualNext;
        rec.taken  = ex_taken;
    end

    // The BHT never backpressures, so the head drains whenever anything is queued.
    assign pop  = ~fifoEmpty;
    assign drop = mis & fifoFull & ~pop;

    sync_fifo #(
        .WIDTH (RECORD_W),
        .DEPTH (QDEPTH)
    ) uUpdateQueue (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (mis),
        .pop_i   (pop),
        .wdata_i (rec),
        .rdata_o (headBits),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    assign head   = br_rec_t'(headBits);
    assign q_full = fifoCount[QAW];

    always_comb begin
        flush_d    = mis;
        redirect_d = mis ? actualNext : redirect_q;
        upd_d      = pop;
        brPc_d     = pop ? head.pc     : brPc_q;
        brTarget_d = pop ? head.target : brTarget_q;
        brIs_d     = pop ? head.taken  : brIs_q;
        cntBr_d    = fire ? cntBr_q   + CNT_W'(1) : cntBr_q;
        cntMis_d   = mis  ? cntMis_q  + CNT_W'(1) : cntMis_q;
        cntDrop_d  = drop ? cntDrop_q + CNT_W'(1) : cntDrop_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
            upd_q      <= 1'b0;
            brPc_q     <= '0;
            brTarget_q <= '0;
            brIs_q     <= 1'b0;
            cntBr_q    <= '0;
            cntMis_q   <= '0;
            cntDrop_q  <= '0;
        end else begin
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            upd_q      <= upd_d;
            brPc_q     <= brPc_d;
            brTarget_q <= brTarget_d;
            brIs_q     <= brIs_d;
            cntBr_q    <= cntBr_d;
            cntMis_q   <= cntMis_d;
            cntDrop_q  <= cntDrop_d;
        end
    end

    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign br_update   = upd_q;
    assign br_pc       = brPc_q;
    assign br_target   = brTarget_q;
    assign br_is       = brIs_q;
    assign cnt_br      = cntBr_q;
    assign cnt_mis     = cntMis_q;
    assign cnt_drop    = cntDrop_q;

endmodule
